handshake_fifo: RTL and testbench
=================================

HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: data width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, a power of two, 2 or more.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold, legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 SHALL have port up_valid, input, 1 bit: upstream word offered.
REQ-007 SHALL have port up_data, input, WORD_WIDTH bits: upstream word.
REQ-008 SHALL have port up_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 SHALL have port down_valid, output, 1 bit: the head word is presented.
REQ-010 SHALL have port down_data, output, WORD_WIDTH bits: the head word.
REQ-011 SHALL have port down_ready, input, 1 bit: downstream accepts the head word.
REQ-012 SHALL have port flush, input, 1 bit: synchronous discard of all entries.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 SHALL have port almost_full, output, 1 bit: count is AF_LEVEL or more.

Function
REQ-015 SHALL define push = up_valid & up_ready and pop = down_valid & down_ready.
REQ-016 SHALL drive up_ready = (count != DEPTH) & ~flush, combinationally from state and flush only, never from down_ready.
REQ-017 SHALL drive down_valid = (count != 0) & ~flush.
REQ-018 SHALL drive down_data = the entry at the read pointer, taken directly from storage with no added register stage.
REQ-019 SHALL, on push, write up_data to the entry at the write pointer and advance the write pointer by 1, wrapping from DEPTH-1 to 0.
REQ-020 SHALL, on pop, advance the read pointer by 1, wrapping from DEPTH-1 to 0.
REQ-021 SHALL update count as follows: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop, or on neither.
REQ-022 SHALL give a latency of 1 cycle: a word pushed into an empty FIFO at edge N is presented with down_valid=1 in the cycle after edge N; there is no combinational path from up to down.
REQ-023 SHALL preserve strict FIFO order with no loss or duplication.
REQ-024 SHALL, when full, refuse the push even if a pop occurs in the same cycle; full throughput is sustained at any count from 1 to DEPTH-1.
REQ-025 SHALL, when empty, allow a push while down_valid stays 0 that cycle.
REQ-026 SHALL keep down_data stable while down_valid=1 and down_ready=0.
REQ-027 SHALL, with flush=1 at an edge, set both pointers to 0 and count to 0, ignoring up_valid and down_ready; storage contents are not cleared.
REQ-028 SHALL give flush priority over push and pop; no handshake completes in a flush cycle.
REQ-029 SHALL derive almost_full from the registered count, updating in the same cycle as count.
REQ-030 SHALL make overflow and underflow structurally impossible; count never exceeds DEPTH.

Reset
REQ-031 SHALL, on rst_n=0 and regardless of clk, set pointers=0, count=0 and all storage entries=0 immediately.
REQ-032 SHALL, during reset, hold up_ready=0 only while flush=1, otherwise 1; down_valid=0, down_data=0, count=0, almost_full=0 (AF_LEVEL of 1 or more).
REQ-033 SHALL, on reset asserted mid-transfer, discard all stored words; the first cycle after release behaves as empty.
REQ-034 SHALL synchronise reset deassertion externally; the block makes no guarantee for release coincident with a clk edge.

Verification (WORD_WIDTH=32, DEPTH=4, AF_LEVEL=3)
REQ-035 SHALL cover fill with down_ready=0 and pushes 0xA0..0xA3 -> count 1,2,3,4; almost_full=1 from count 3; up_ready=0 at count 4; a fifth up_valid is not accepted.
REQ-036 SHALL cover drain from full with down_ready=1 -> down_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; then down_valid=0, count=0, up_ready=1.
REQ-037 SHALL cover streaming with up_valid and down_ready both held 1 for 20 cycles and data 1..20 -> count steady at 1 after the first cycle; output 1..20 in order, one word per cycle.
REQ-038 SHALL cover wrap-around across 10 push/pop rounds with random down_ready stalls -> pointers wrap 3->0; scoreboard shows no loss or reorder; down_data stable during stalls.
REQ-039 SHALL cover flush at count=3 with up_valid=1 and down_ready=1 in the flush cycle -> the next cycle has count=0 and down_valid=0; the flush-cycle word is not stored; the next push 0x55 appears as the head.
REQ-040 SHALL cover rst_n pulled low between clk edges at count=2 -> count=0, down_valid=0 and down_data=0 immediately, before the next edge.

Source files
------------

// File: rtl/handshake_fifo.sv
// handshake_fifo
//   Single-clock valid/ready FIFO with one cycle of latency, synchronous
//   flush and an occupancy-based almost_full flag.
//
// Parameters
//   WORD_WIDTH  data width in bits (>= 1)
//   DEPTH       number of entries, power of two, >= 2
//   AF_LEVEL    almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears pointers, count, storage
//   up_valid     upstream word offered
//   up_data      upstream word
//   up_ready     FIFO can accept a word this cycle (not full, no flush)
//   down_valid   head word presented (not empty, no flush)
//   down_data    head word, read straight from storage
//   down_ready   downstream accepts the head word
//   flush        synchronous discard of all entries; wins over push/pop
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AF_LEVEL
module handshake_fifo #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         up_valid,
  input  logic [WORD_WIDTH-1:0]        up_data,
  output logic                         up_ready,
  output logic                         down_valid,
  output logic [WORD_WIDTH-1:0]        down_data,
  input  logic                         down_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic                  push;
  logic                  pop;

  // up_ready depends only on occupancy and flush, so a full FIFO refuses a
  // push even when the head is being popped in the same cycle. Gating both
  // handshakes with ~flush is what makes flush win over push and pop.
  assign up_ready    = (occ != FULL_COUNT) & ~flush;
  assign down_valid  = (occ != '0) & ~flush;
  assign down_data   = mem[rd_ptr];
  assign count       = occ;
  assign almost_full = (occ >= AF_COUNT);

  assign push = up_valid & up_ready;
  assign pop  = down_valid & down_ready;

  // Storage is cleared only by reset; flush leaves stale words in place
  // since the pointers and count make them unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= up_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged. The ready and
  // valid gating keeps it within 0..DEPTH without extra saturation logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (push && !pop) begin
      occ <= occ + CW'(1);
    end else if (pop && !push) begin
      occ <= occ - CW'(1);
    end
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo
//   Self-checking bench for handshake_fifo (WORD_WIDTH=32, DEPTH=4,
//   AF_LEVEL=3). A queue-based reference model predicts every output at each
//   falling edge; directed sequences add hand-computed literal expectations.
module tb_handshake_fifo;

  localparam int WW    = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic          clk;
  logic          rst_n;
  logic          up_valid;
  logic [WW-1:0] up_data;
  logic          up_ready;
  logic          down_valid;
  logic [WW-1:0] down_data;
  logic          down_ready;
  logic          flush;
  logic [2:0]    count;
  logic          almost_full;

  int tests = 0;
  int fails = 0;

  logic [WW-1:0] q[$];
  bit            plan_push  = 0;
  bit            plan_pop   = 0;
  bit            plan_flush = 0;
  logic [WW-1:0] plan_data  = '0;

  handshake_fifo #(
    .WORD_WIDTH(WW),
    .DEPTH(DEPTH),
    .AF_LEVEL(AF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .up_valid(up_valid),
    .up_data(up_data),
    .up_ready(up_ready),
    .down_valid(down_valid),
    .down_data(down_data),
    .down_ready(down_ready),
    .flush(flush),
    .count(count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change just after the rising edge and hold for a full cycle.
  task automatic applyStimulus(input logic v, input logic [WW-1:0] d,
                               input logic r, input logic f);
    @(posedge clk);
    #1;
    up_valid   = v;
    up_data    = d;
    down_ready = r;
    flush      = f;
  endtask

  // Reference model check: outputs follow from queue occupancy and flush.
  // The handshakes that will complete at the next rising edge are planned
  // here, since inputs are stable between this edge and that one.
  always @(negedge clk) begin
    bit exp_ur;
    bit exp_dv;
    if (!rst_n) q.delete();
    exp_ur = (q.size() != DEPTH) && !flush;
    exp_dv = (q.size() != 0) && !flush;
    checkOutput("model up_ready", up_ready, exp_ur);
    checkOutput("model down_valid", down_valid, exp_dv);
    checkOutput("model count", count, q.size());
    checkOutput("model almost_full", almost_full, q.size() >= AF);
    if (exp_dv) checkOutput("model down_data", down_data, q[0]);
    plan_push  = up_valid && exp_ur;
    plan_pop   = exp_dv && down_ready;
    plan_flush = flush;
    plan_data  = up_data;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (plan_flush) begin
        q.delete();
      end else begin
        if (plan_pop) void'(q.pop_front());
        if (plan_push) q.push_back(plan_data);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    flush      = 1'b1;

    // Reset state, including up_ready following flush while in reset.
    #2;
    checkOutput("reset up_ready with flush", up_ready, 0);
    flush = 1'b0;
    #1;
    checkOutput("reset up_ready", up_ready, 1);
    checkOutput("reset down_valid", down_valid, 0);
    checkOutput("reset down_data", down_data, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset almost_full", almost_full, 0);
    #5;
    rst_n = 1'b1;

    // Fill with downstream stalled; the fifth offer must be refused.
    for (int i = 0; i < 6; i++) begin
      automatic int c = (i > 4) ? 4 : i;
      applyStimulus(i < 5, 32'hA0 + i, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("fill count", count, c);
      checkOutput("fill almost_full", almost_full, c >= 3);
      checkOutput("fill up_ready", up_ready, c != 4);
    end

    // Drain from full, one word per cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("drain down_data", down_data, 32'hA0 + i);
      checkOutput("drain count", count, 4 - i);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drained down_valid", down_valid, 0);
    checkOutput("drained count", count, 0);
    checkOutput("drained up_ready", up_ready, 1);

    // Streaming: push and pop every cycle, occupancy settles at 1.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, WW'(i), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stream count", count, (i == 1) ? 0 : 1);
      if (i > 1) checkOutput("stream down_data", down_data, i - 1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream last word", down_data, 20);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stream empty count", count, 0);

    // Random traffic with stalls, wrapping the pointers many times.
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    @(negedge clk);
    checkOutput("pre-flush empty", count, 0);

    // Flush at count 3 with both sides handshaking; nothing completes.
    applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB3, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush-cycle count", count, 3);
    checkOutput("flush-cycle up_ready", up_ready, 0);
    checkOutput("flush-cycle down_valid", down_valid, 0);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post-flush count", count, 0);
    checkOutput("post-flush down_valid", down_valid, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post-flush head valid", down_valid, 1);
    checkOutput("post-flush head", down_data, 32'h55);
    checkOutput("post-flush head count", count, 1);

    // Asynchronous reset between edges at count 2.
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("pre-reset count", count, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset count", count, 0);
    checkOutput("async reset down_valid", down_valid, 0);
    checkOutput("async reset down_data", down_data, 0);
    checkOutput("async reset almost_full", almost_full, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // More random traffic after reset release, including occasional flush.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
